rsnn_spike_counter: RTL and testbench

- Output readout stage, directly downstream of the RSNN core in tt_um_chatgpt_rsnn_paolaunisa.
- Counts output-neuron spikes over a programmable window of network time steps and latches the per-neuron counts.
- Scans the latched counts to produce a winner index (argmax) with a tie flag and a one-cycle valid pulse; this result drives uo_out.
- Also exposes any latched count through a read-select mux.

---
 rtl/rsnn_spike_counter.sv | 148 ++++++++++++++
 tb/tb_rsnn_spike_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rsnn_spike_counter.sv
// Spike readout: windowed per-neuron spike counters, latched count bank, argmax winner with tie flag.
// Latency: winner_valid pulses N_NEURONS+1 cycles after the window-closing step edge; count_rd is combinational.
// Backpressure: none; a window closing mid-scan restarts the scan, drops its pulse and sets sticky overrun.
module rsnn_spike_counter #(
  parameter int  N_NEURONS = 8,
  parameter int  CNT_W     = 8,
  parameter int  WIN_W     = 8,
  localparam int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 step,
  input  logic [N_NEURONS-1:0] spikes,
  input  logic [WIN_W-1:0]     window_len,
  input  logic                 clear,
  input  logic [IDX_W-1:0]     count_sel,
  output logic [CNT_W-1:0]     count_rd,
  output logic [IDX_W-1:0]     winner,
  output logic                 tie,
  output logic                 winner_valid,
  output logic                 overrun
);

  typedef enum logic [1:0] {ACCUM, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] live     [N_NEURONS];
  logic [CNT_W-1:0] latched  [N_NEURONS];
  logic [CNT_W-1:0] live_sum [N_NEURONS];
  logic [WIN_W-1:0] step_cnt;
  logic [WIN_W-1:0] lim_m1;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] best_idx;
  logic [CNT_W-1:0] best;
  logic             tie_r;
  logic             accept;
  logic             close;
  logic             done_fire;

  // A window length of 0 behaves as 1; using >= lets a shortened window close on the next step.
  assign lim_m1    = (window_len == '0) ? '0 : window_len - WIN_W'(1);
  assign accept    = step & ena & ~clear;
  assign close     = accept && (step_cnt >= lim_m1);
  assign done_fire = (state == DONE) && !close && !clear;
  assign count_rd  = latched[count_sel];

  // Saturating per-neuron increment for the current step's spikes.
  always_comb begin
    for (int i = 0; i < N_NEURONS; i++) begin
      live_sum[i] = live[i];
      if (spikes[i] && (live[i] != CNT_MAX)) begin
        live_sum[i] = live[i] + CNT_W'(1);
      end
    end
  end

  // Live accumulation, window step counter and latching of the finished window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        live[i]    <= '0;
        latched[i] <= '0;
      end
    end else if (clear) begin
      step_cnt <= '0;
      for (int i = 0; i < N_NEURONS; i++) live[i] <= '0;
    end else if (accept) begin
      if (close) begin
        step_cnt <= '0;
        for (int i = 0; i < N_NEURONS; i++) begin
          latched[i] <= live_sum[i];
          live[i]    <= '0;
        end
      end else begin
        step_cnt <= step_cnt + WIN_W'(1);
        for (int i = 0; i < N_NEURONS; i++) live[i] <= live_sum[i];
      end
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // Next state: a window close always (re)starts the scan; clear wins over everything.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   state_nxt = ACCUM;
      SCAN:    if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
    if (close) state_nxt = SCAN;
    if (clear) state_nxt = ACCUM;
  end

  // Argmax walk over the latched bank, one index per cycle; strict > keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      best     <= '0;
      best_idx <= '0;
      tie_r    <= 1'b0;
    end else if (clear || close) begin
      idx <= '0;
    end else if (state == SCAN) begin
      idx <= idx + IDX_W'(1);
      if (idx == '0) begin
        best     <= latched[0];
        best_idx <= '0;
        tie_r    <= 1'b0;
      end else if (latched[idx] > best) begin
        best     <= latched[idx];
        best_idx <= idx;
        tie_r    <= 1'b0;
      end else if (latched[idx] == best) begin
        tie_r <= 1'b1;
      end
    end
  end

  // Result registers, the one-cycle valid pulse and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner       <= '0;
      tie          <= 1'b0;
      winner_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      winner_valid <= done_fire;
      if (done_fire) begin
        winner <= best_idx;
        tie    <= tie_r;
      end
      if (clear) overrun <= 1'b0;
      else if (close && (state != ACCUM)) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rsnn_spike_counter.sv
// Directed bench for rsnn_spike_counter: reset, argmax, tie, saturation, window_len=0, ena gating, overrun, clear.
// A second instance with 2-bit counters shares all inputs so that counter saturation is observable.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_rsnn_spike_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       step = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] spikes = '0;
  logic [7:0] window_len = '0;
  logic [2:0] count_sel = '0;

  logic [7:0] count_rd;
  logic [2:0] winner;
  logic       tie, winner_valid, overrun;
  logic [1:0] s_count_rd;
  logic [2:0] s_winner;
  logic       s_tie, s_winner_valid, s_overrun;

  int errors = 0;
  int checks = 0;
  int vld_cnt = 0;

  rsnn_spike_counter #(.N_NEURONS(8), .CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .step(step), .spikes(spikes),
    .window_len(window_len), .clear(clear), .count_sel(count_sel),
    .count_rd(count_rd), .winner(winner), .tie(tie),
    .winner_valid(winner_valid), .overrun(overrun)
  );

  rsnn_spike_counter #(.N_NEURONS(8), .CNT_W(2), .WIN_W(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .step(step), .spikes(spikes),
    .window_len(window_len), .clear(clear), .count_sel(count_sel),
    .count_rd(s_count_rd), .winner(s_winner), .tie(s_tie),
    .winner_valid(s_winner_valid), .overrun(s_overrun)
  );

  always #5 clk = ~clk;

  // Count every winner_valid pulse seen by the main instance.
  always @(negedge clk) if (winner_valid === 1'b1) vld_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycles from the current edge until winner_valid is seen; 0 means it never came.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (winner_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_steps(input logic [7:0] spk, input int n);
    step   = 1'b1;
    spikes = spk;
    for (int k = 0; k < n; k++) tick();
    step   = 1'b0;
    spikes = '0;
  endtask

  task automatic test_reset();
    int v0;
    tick(); tick();
    checks++; if (count_rd !== 8'd0) begin errors++; $display("FAIL reset_count_rd: got %0d want 0", count_rd); end
    checks++; if (winner !== 3'd0) begin errors++; $display("FAIL reset_winner: got %0d want 0", winner); end
    checks++; if (tie !== 1'b0) begin errors++; $display("FAIL reset_tie: got %b want 0", tie); end
    checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", winner_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    rst_n = 1'b1; ena = 1'b1; window_len = 8'd2;
    tick();
    run_steps(8'h01, 2);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++; if (count_rd !== 8'd0) begin errors++; $display("FAIL midscan_reset_count: got %0d want 0", count_rd); end
    checks++; if ({winner, tie, winner_valid, overrun} !== 6'd0) begin
      errors++; $display("FAIL midscan_reset_outs: got %b want 000000", {winner, tie, winner_valid, overrun}); end
    tick();
    rst_n = 1'b1;
    v0 = vld_cnt;
    repeat (15) tick();
    checks++; if (vld_cnt !== v0) begin errors++; $display("FAIL midscan_reset_pulse: got %0d pulses want 0", vld_cnt - v0); end
  endtask

  task automatic test_basic();
    int lat;
    window_len = 8'd4;
    run_steps(8'h08, 4);
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d want 9", lat); end
    checks++; if (winner !== 3'd3) begin errors++; $display("FAIL basic_winner: got %0d want 3", winner); end
    checks++; if (tie !== 1'b0) begin errors++; $display("FAIL basic_tie: got %b want 0", tie); end
    tick();
    checks++; if (winner_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b want 0", winner_valid); end
    count_sel = 3'd3; #1;
    checks++; if (count_rd !== 8'd4) begin errors++; $display("FAIL basic_count3: got %0d want 4", count_rd); end
    count_sel = 3'd0; #1;
    checks++; if (count_rd !== 8'd0) begin errors++; $display("FAIL basic_count0: got %0d want 0", count_rd); end
  endtask

  task automatic test_tie();
    int lat;
    window_len = 8'd3;
    run_steps(8'h24, 3);
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL tie_latency: got %0d want 9", lat); end
    checks++; if (winner !== 3'd2) begin errors++; $display("FAIL tie_winner: got %0d want 2", winner); end
    checks++; if (tie !== 1'b1) begin errors++; $display("FAIL tie_flag: got %b want 1", tie); end
    count_sel = 3'd5; #1;
    checks++; if (count_rd !== 8'd3) begin errors++; $display("FAIL tie_count5: got %0d want 3", count_rd); end
  endtask

  task automatic test_saturation();
    int lat;
    window_len = 8'hFF;
    run_steps(8'h01, 255);
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL sat_latency: got %0d want 9", lat); end
    checks++; if (s_winner_valid !== 1'b1) begin errors++; $display("FAIL sat_small_valid: got %b want 1", s_winner_valid); end
    count_sel = 3'd0; #1;
    checks++; if (count_rd !== 8'd255) begin errors++; $display("FAIL sat_count0: got %0d want 255", count_rd); end
    checks++; if (s_count_rd !== 2'd3) begin errors++; $display("FAIL sat_small_count0: got %0d want 3", s_count_rd); end
    checks++; if ({s_winner, s_tie, s_overrun} !== 5'd0) begin
      errors++; $display("FAIL sat_small_result: got %b want 00000", {s_winner, s_tie, s_overrun}); end
    checks++; if ({winner, tie} !== 4'd0) begin errors++; $display("FAIL sat_result: got %b want 0000", {winner, tie}); end
  endtask

  task automatic test_win0_ena();
    int lat, v0;
    window_len = 8'd0;
    run_steps(8'h02, 1);
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL win0_latency: got %0d want 9", lat); end
    checks++; if (winner !== 3'd1) begin errors++; $display("FAIL win0_winner: got %0d want 1", winner); end
    repeat (3) tick();
    ena = 1'b0;
    v0 = vld_cnt;
    run_steps(8'hFF, 5);
    repeat (15) tick();
    checks++; if (vld_cnt !== v0) begin errors++; $display("FAIL ena_gate_pulse: got %0d pulses want 0", vld_cnt - v0); end
    count_sel = 3'd1; #1;
    checks++; if (count_rd !== 8'd1) begin errors++; $display("FAIL ena_gate_count1: got %0d want 1", count_rd); end
    ena = 1'b1;
    run_steps(8'h04, 1);
    ena = 1'b0;
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL ena_scan_latency: got %0d want 9", lat); end
    checks++; if (winner !== 3'd2) begin errors++; $display("FAIL ena_scan_winner: got %0d want 2", winner); end
    ena = 1'b1;
    repeat (2) tick();
    run_steps(8'h01, 1);
    wait_valid(lat);
    count_sel = 3'd7; #1;
    checks++; if (count_rd !== 8'd0) begin errors++; $display("FAIL ena_gate_count7: got %0d want 0", count_rd); end
    count_sel = 3'd0; #1;
    checks++; if (count_rd !== 8'd1) begin errors++; $display("FAIL win0_count0: got %0d want 1", count_rd); end
  endtask

  task automatic test_overrun();
    int lat, v0;
    repeat (3) tick();
    window_len = 8'd1;
    v0 = vld_cnt;
    step = 1'b1;
    spikes = 8'h01; tick();
    spikes = 8'h02; tick();
    spikes = 8'h10; tick();
    step = 1'b0; spikes = '0;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL overrun_latency: got %0d want 9", lat); end
    checks++; if (winner !== 3'd4) begin errors++; $display("FAIL overrun_winner: got %0d want 4", winner); end
    repeat (12) tick();
    checks++; if (vld_cnt - v0 !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", vld_cnt - v0); end
    clear = 1'b1; tick(); clear = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clear_overrun: got %b want 0", overrun); end
    count_sel = 3'd4; #1;
    checks++; if (count_rd !== 8'd1) begin errors++; $display("FAIL clear_holds_latched: got %0d want 1", count_rd); end
    checks++; if (winner !== 3'd4) begin errors++; $display("FAIL clear_holds_winner: got %0d want 4", winner); end
  endtask

  task automatic test_clear_vs_step();
    int lat;
    window_len = 8'd2;
    clear = 1'b1; step = 1'b1; spikes = 8'hFF;
    tick();
    clear = 1'b0;
    run_steps(8'h01, 2);
    wait_valid(lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL clrstep_latency: got %0d want 9", lat); end
    count_sel = 3'd0; #1;
    checks++; if (count_rd !== 8'd2) begin errors++; $display("FAIL clrstep_count0: got %0d want 2", count_rd); end
    count_sel = 3'd1; #1;
    checks++; if (count_rd !== 8'd0) begin errors++; $display("FAIL clrstep_count1: got %0d want 0", count_rd); end
    checks++; if ({winner, tie} !== 4'd0) begin errors++; $display("FAIL clrstep_result: got %b want 0000", {winner, tie}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_win0_ena();
    test_overrun();
    test_clear_vs_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
